// File: rtl/spi_txn_pkg.sv
// spi_txn_pkg: protocol words, FSM state encoding and word-index width for spi_txn_arbiter
package spi_txn_pkg;
  localparam logic [15:0] W_START   = 16'd1;
  localparam logic [15:0] W_WRITE   = 16'd2;
  localparam logic [15:0] W_READ    = 16'd3;
  localparam logic [15:0] W_SUCCESS = 16'd20;
  localparam logic [15:0] W_STOP    = 16'd22;
  localparam logic [15:0] W_FAIL    = 16'd27;
  localparam int IDX_W = 3;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_XFER, S_CHECK, S_ERRW, S_FINISH} state_e;
endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// spi_rr_arbiter: combinational round-robin pick of the first valid requester at or after the pointer
module spi_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [2:0]   ptr_i,
  output logic [2:0]   gnt_o,
  output logic         found_o
);
  logic [N-1:0] rot;
  logic [3:0]   sum;
  always_comb begin
    rot = N'({valid_i, valid_i} >> ptr_i);
    gnt_o = '0;
    found_o = 1'b0;
    sum = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = 4'(ptr_i) + 4'(i);
        gnt_o = 3'(sum >= 4'(N) ? sum - 4'(N) : sum);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin SPI register-transaction sequencer; SPI_TXN_ARB_TIMEOUT_EN adds a per-word watchdog
module spi_txn_arbiter
  import spi_txn_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk210_p,
  input  logic                  reset_p,
  input  logic [NUM_REQ-1:0]    req_valid_p,
  input  logic [NUM_REQ-1:0]    req_rw_p,
  input  logic [NUM_REQ*16-1:0] req_addr_p,
  input  logic [NUM_REQ*16-1:0] req_wdata_p,
  output logic [NUM_REQ-1:0]    req_ack_p,
  output logic                  req_err_p,
  output logic [15:0]           rsp_rdata_p,
  output logic [2:0]            grant_id_p,
  output logic                  busy_p,
  output logic                  spi_ss_p,
  output logic [15:0]           spi_word_out_p,
  output logic                  spi_init_trans_p,
  input  logic [15:0]           spi_word_in_p,
  input  logic                  spi_word_done_p
);
  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 err_q, rw_q, ss_q, init_q, rerr_q, busy_q, pass_d, arb_found;
  logic [15:0]          addr_q, wdata_q, rx_q, word_q, rdata_q, word_d;
  logic [2:0]           gnt_q, ptr_q, arb_gnt;
  logic [NUM_REQ-1:0]   ack_q;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
  logic [15:0]          wd_q;
`else
  logic                 unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYC);
`endif
  spi_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .valid_i(req_valid_p),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .found_o(arb_found)
  );
  always_comb begin
    word_d = err_q ? W_FAIL :
             idx_q == IDX_W'(0) ? W_START :
             idx_q == IDX_W'(1) ? (rw_q ? W_READ : W_WRITE) :
             idx_q == IDX_W'(2) ? addr_q :
             idx_q == IDX_W'(3) ? (rw_q ? 16'h0 : wdata_q) : W_STOP;
    pass_d = idx_q == IDX_W'(0) ? rx_q == 16'h0 :
             idx_q == IDX_W'(1) ? rx_q == W_SUCCESS : 1'b1;
  end
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rx_q    <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      ss_q    <= 1'b1;
      init_q  <= 1'b0;
      word_q  <= '0;
      ack_q   <= '0;
      rerr_q  <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          // the acked requester still shows valid during its ack cycle, so hold off one cycle
          if (arb_found && ack_q == '0) begin
            gnt_q   <= arb_gnt;
            busy_q  <= 1'b1;
            rw_q    <= 1'(req_rw_p >> arb_gnt);
            addr_q  <= 16'(req_addr_p >> {arb_gnt, 4'b0});
            wdata_q <= 16'(req_wdata_p >> {arb_gnt, 4'b0});
            idx_q   <= '0;
            err_q   <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          word_q  <= word_d;
          ss_q    <= 1'b0;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
          wd_q    <= '0;
`endif
          state_q <= S_XFER;
        end
        S_XFER: begin
          if (init_q && spi_word_done_p) begin
            init_q  <= 1'b0;
            rx_q    <= spi_word_in_p;
            state_q <= S_CHECK;
          end
`ifdef SPI_TXN_ARB_TIMEOUT_EN
          else if (wd_q == 16'(TIMEOUT_CYC - 1)) begin
            init_q  <= 1'b0;
            ss_q    <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            init_q <= 1'b1;
            wd_q   <= wd_q + 16'd1;
          end
`else
          else init_q <= 1'b1;
`endif
        end
        S_CHECK: begin
          if (err_q || idx_q == IDX_W'(4)) state_q <= S_FINISH;
          else if (!pass_d) state_q <= S_ERRW;
          else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_LOAD;
          end
        end
        S_ERRW: begin
          err_q   <= 1'b1;
          state_q <= S_LOAD;
        end
        S_FINISH: begin
          ss_q    <= 1'b1;
          ack_q   <= NUM_REQ'(1) << gnt_q;
          rerr_q  <= err_q;
          if (rw_q && !err_q) rdata_q <= rx_q;
          ptr_q   <= (gnt_q == 3'(NUM_REQ - 1)) ? '0 : gnt_q + 3'd1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign req_ack_p        = ack_q;
  assign req_err_p        = rerr_q;
  assign rsp_rdata_p      = rdata_q;
  assign grant_id_p       = gnt_q;
  assign busy_p           = busy_q;
  assign spi_ss_p         = ss_q;
  assign spi_word_out_p   = word_q;
  assign spi_init_trans_p = init_q;
endmodule
